// File: rtl/subleq_core_hs.sv
// SUBLEQ execution core with a req/ack memory port, run/step control,
// halt-address detection and a saturating retired-instruction counter.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for run or a step pulse; no memory access
// FETCH_A  | read operand address A from pc
// FETCH_B  | read operand address B from pc+1
// FETCH_C  | read branch target C from pc+2
// DEREF_A  | read mem[A] into va
// DEREF_B  | read mem[B] into vb
// STORE    | write vb-va to mem[B], resolve branch, retire
// HALT     | pc reached HALT_ADDR; only reset leaves this state
module subleq_core_hs #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] HALT_ADDR = {WORD_SIZE{1'b1}},
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   CNT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 run,
  input  logic                 step,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 halted,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] pc,
  output logic [CNT_BITS-1:0]  insn_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_DEREF_A,
    S_DEREF_B,
    S_STORE,
    S_HALT
  } state_t;

  state_t               state, state_d;
  logic [WORD_SIZE-1:0] pc_q, a_q, b_q, c_q, va_q, vb_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic [WORD_SIZE-1:0] res, npc;
  logic                 take_branch, done;

  // Branch when the result is zero or negative as a two's-complement value.
  assign res         = vb_q - va_q;
  assign take_branch = (res == '0) || res[WORD_SIZE-1];
  assign npc         = take_branch ? c_q : pc_q + WORD_SIZE'(3);
  assign done        = mem_req && mem_ack;

  assign pc         = pc_q;
  assign insn_count = cnt_q;

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state <= S_IDLE;
      pc_q  <= RESET_PC;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      va_q  <= '0;
      vb_q  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      if (done) begin
        case (state)
          S_FETCH_A: a_q  <= mem_rdata;
          S_FETCH_B: b_q  <= mem_rdata;
          S_FETCH_C: c_q  <= mem_rdata;
          S_DEREF_A: va_q <= mem_rdata;
          S_DEREF_B: vb_q <= mem_rdata;
          S_STORE: begin
            pc_q <= npc;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_BITS'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Access outputs depend only on registered state, so they hold steady until ack.
  always_comb begin
    state_d   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH_A;
      end
      S_FETCH_A: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) state_d = S_FETCH_B;
      end
      S_FETCH_B: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = pc_q + WORD_SIZE'(1);
        if (mem_ack) state_d = S_FETCH_C;
      end
      S_FETCH_C: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = pc_q + WORD_SIZE'(2);
        if (mem_ack) state_d = S_DEREF_A;
      end
      S_DEREF_A: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = a_q;
        if (mem_ack) state_d = S_DEREF_B;
      end
      S_DEREF_B: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = b_q;
        if (mem_ack) state_d = S_STORE;
      end
      S_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        busy      = 1'b1;
        mem_addr  = b_q;
        mem_wdata = res;
        if (mem_ack) begin
          if (npc == HALT_ADDR) state_d = S_HALT;
          else if (run)         state_d = S_FETCH_A;
          else                  state_d = S_IDLE;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_subleq_core_hs.sv
// Self-checking bench for subleq_core_hs: a memory model with optional wait
// states acks requests and checks every write against a queue of expected stores.
module tb_subleq_core_hs;
  localparam int W  = 16;
  localparam int CB = 32;

  logic          clk = 1'b0;
  logic          areset_n, run, step;
  logic          mem_req, mem_we, halted, busy;
  logic          mem_ack = 1'b0;
  logic [W-1:0]  mem_addr, mem_wdata, pc;
  logic [W-1:0]  mem_rdata = '0;
  logic [CB-1:0] insn_count;

  always #5 clk = ~clk;

  subleq_core_hs dut (
    .clk(clk), .areset_n(areset_n), .run(run), .step(step),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .busy(busy), .pc(pc), .insn_count(insn_count)
  );

  typedef struct packed { logic [W-1:0] addr; logic [W-1:0] data; } wr_t;
  typedef struct packed { logic we; logic [W-1:0] addr; } acc_t;

  logic [W-1:0] mem [0:65535];
  wr_t          exp_wr[$];
  acc_t         acc_log[$];
  wr_t          e_wr;
  int           errors = 0;
  int           checks = 0;
  int           max_delay = 0;
  int           stall_after = -1;
  int           wait_left = 0;
  bit           in_acc = 1'b0;
  logic [W-1:0] hold_addr, hold_wdata;
  logic         hold_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder and write monitor; runs on the falling edge.
  always @(negedge clk) begin
    if (in_acc && mem_req) begin
      check("hold_addr", {16'h0, mem_addr}, {16'h0, hold_addr});
      check("hold_we", {31'h0, mem_we}, {31'h0, hold_we});
      check("hold_wdata", {16'h0, mem_wdata}, {16'h0, hold_wdata});
    end
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!in_acc) wait_left = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
      if (wait_left == 0 && !(stall_after >= 0 && acc_log.size() >= stall_after)) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        in_acc    = 1'b0;
        acc_log.push_back(acc_t'{we: mem_we, addr: mem_addr});
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
          end else begin
            e_wr = exp_wr.pop_front();
            check("wr_addr", {16'h0, mem_addr}, {16'h0, e_wr.addr});
            check("wr_data", {16'h0, mem_wdata}, {16'h0, e_wr.data});
          end
        end
      end else begin
        if (wait_left > 0) wait_left--;
        in_acc     = 1'b1;
        hold_addr  = mem_addr;
        hold_we    = mem_we;
        hold_wdata = mem_wdata;
      end
    end else begin
      in_acc = 1'b0;
    end
  end

  task automatic clear_env();
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    exp_wr.delete();
    acc_log.delete();
    max_delay   = 0;
    stall_after = -1;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_env();
    areset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_not_busy(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, busy}, 32'h0);
  endtask

  task automatic load_prog2();
    mem[0] = 16'd3;  mem[1] = 16'd4;  mem[2] = 16'd9;
    mem[3] = 16'd5;  mem[4] = 16'd7;  mem[5] = 16'hFFFF;
    mem[6] = 16'd20; mem[7] = 16'd20; mem[8] = 16'hFFFF;
    exp_wr.push_back(wr_t'{addr: 16'd4,  data: 16'd2});
    exp_wr.push_back(wr_t'{addr: 16'd2,  data: 16'd10});
    exp_wr.push_back(wr_t'{addr: 16'd20, data: 16'd0});
  endtask

  int           cyc;
  int           chg[$];
  logic [W-1:0] prev_pc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset held with run high
    areset_n = 1'b0;
    run      = 1'b1;
    step     = 1'b0;
    clear_env();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req", {31'h0, mem_req}, 32'h0);
      check("rst_pc", {16'h0, pc}, 32'h0);
      check("rst_cnt", insn_count, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
    end
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_addr", {16'h0, mem_addr}, 32'h0);
    run = 1'b0;
    areset_n = 1'b1;
    @(negedge clk);

    // Zero-wait run: no-branch, positive result, self-store halt
    do_reset();
    load_prog2();
    run = 1'b1;
    cyc = 0;
    chg.delete();
    prev_pc = pc;
    while (!halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pc !== prev_pc) begin
        chg.push_back(cyc);
        prev_pc = pc;
      end
    end
    check("t2_halted", {31'h0, halted}, 32'h1);
    check("t2_pc_changes", chg.size(), 32'd3);
    if (chg.size() == 3) begin
      check("t2_first_retire_cycle", chg[0], 32'd7);
      check("t2_cycles_insn2", chg[1] - chg[0], 32'd6);
      check("t2_cycles_insn3", chg[2] - chg[1], 32'd6);
    end
    check("t2_pc", {16'h0, pc}, 32'hFFFF);
    check("t2_cnt", insn_count, 32'd3);
    repeat (5) @(negedge clk);
    check("t2_halt_req", {31'h0, mem_req}, 32'h0);
    check("t2_halt_busy", {31'h0, busy}, 32'h0);
    run = 1'b0;
    pulse_step();
    repeat (8) @(negedge clk);
    check("t2_halt_sticky", {31'h0, halted}, 32'h1);
    check("t2_halt_cnt", insn_count, 32'd3);
    check("t2_mem4", {16'h0, mem[4]}, 32'd2);
    check("t2_exp_empty", exp_wr.size(), 32'd0);

    // Single steps: zero result and 0x8000 result both branch
    do_reset();
    mem[0]  = 16'd3;  mem[1]  = 16'd4;  mem[2]  = 16'd12;
    mem[3]  = 16'd7;  mem[4]  = 16'd7;
    mem[12] = 16'd20; mem[13] = 16'd21; mem[14] = 16'd30;
    mem[20] = 16'd1;  mem[21] = 16'h8001;
    exp_wr.push_back(wr_t'{addr: 16'd4,  data: 16'd0});
    exp_wr.push_back(wr_t'{addr: 16'd21, data: 16'h8000});
    pulse_step();
    check("t3_step_busy", {31'h0, busy}, 32'h1);
    wait_not_busy("t3_step1_timeout", 50);
    check("t3_pc_zero_branch", {16'h0, pc}, 32'd12);
    check("t3_cnt1", insn_count, 32'd1);
    repeat (10) @(negedge clk);
    check("t3_one_step_only", insn_count, 32'd1);
    check("t3_idle_req", {31'h0, mem_req}, 32'h0);
    check("t3_not_halted", {31'h0, halted}, 32'h0);
    pulse_step();
    wait_not_busy("t3_step2_timeout", 50);
    check("t3_pc_neg_branch", {16'h0, pc}, 32'd30);
    check("t3_cnt2", insn_count, 32'd2);
    check("t3_exp_empty", exp_wr.size(), 32'd0);

    // Random wait states; same program as the zero-wait run
    do_reset();
    load_prog2();
    max_delay = 5;
    run = 1'b1;
    cyc = 0;
    while (!halted && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    run = 1'b0;
    check("t4_halted", {31'h0, halted}, 32'h1);
    check("t4_pc", {16'h0, pc}, 32'hFFFF);
    check("t4_cnt", insn_count, 32'd3);
    check("t4_mem2", {16'h0, mem[2]}, 32'd10);
    check("t4_mem4", {16'h0, mem[4]}, 32'd2);
    check("t4_mem20", {16'h0, mem[20]}, 32'd0);
    check("t4_mem3", {16'h0, mem[3]}, 32'd5);
    check("t4_exp_empty", exp_wr.size(), 32'd0);

    // pc wrap across 0xFFFF, then reset during a stalled DEREF_B
    do_reset();
    mem[0] = 16'd10; mem[1] = 16'd10; mem[2] = 16'hFFFE;
    mem[16'hFFFE] = 16'd40; mem[16'hFFFF] = 16'd41;
    mem[40] = 16'd0; mem[41] = 16'd5;
    exp_wr.push_back(wr_t'{addr: 16'd10, data: 16'd0});
    exp_wr.push_back(wr_t'{addr: 16'd41, data: 16'd5});
    pulse_step();
    wait_not_busy("t6_step1_timeout", 50);
    check("t6_pc_fffe", {16'h0, pc}, 32'hFFFE);
    acc_log.delete();
    pulse_step();
    wait_not_busy("t6_step2_timeout", 50);
    check("t6_acc_count", acc_log.size(), 32'd6);
    if (acc_log.size() == 6) begin
      check("t6_fetch_a_addr", {16'h0, acc_log[0].addr}, 32'hFFFE);
      check("t6_fetch_b_addr", {16'h0, acc_log[1].addr}, 32'hFFFF);
      check("t6_fetch_c_addr", {16'h0, acc_log[2].addr}, 32'h0000);
      check("t6_store_we", {31'h0, acc_log[5].we}, 32'h1);
    end
    check("t6_pc_wrap", {16'h0, pc}, 32'h0001);
    check("t6_cnt", insn_count, 32'd2);
    acc_log.delete();
    stall_after = 4;
    pulse_step();
    repeat (6) @(negedge clk);
    check("t6_stall_req", {31'h0, mem_req}, 32'h1);
    check("t6_stall_addr", {16'h0, mem_addr}, 32'hFFFE);
    check("t6_stall_we", {31'h0, mem_we}, 32'h0);
    areset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_req", {31'h0, mem_req}, 32'h0);
    check("t6_rst_busy", {31'h0, busy}, 32'h0);
    check("t6_rst_halted", {31'h0, halted}, 32'h0);
    check("t6_rst_pc", {16'h0, pc}, 32'h0);
    check("t6_rst_cnt", insn_count, 32'h0);
    areset_n = 1'b1;
    stall_after = -1;
    @(negedge clk);
    check("t6_idle_after_rst", {31'h0, mem_req}, 32'h0);
    check("t6_exp_empty", exp_wr.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
